// File: rtl/avalon_debug_event_poller.sv
// avalon_debug_event_poller
//
// Avalon-MM read master that periodically polls a single-register debug-event
// capture slave. Each 64-bit snapshot carries an 8-bit sequence counter in
// [63:56] and the latest 5-bit debug code in [4:0]. A change of sequence
// number is treated as a new event. The number of events missed between polls
// is computed, and a {code, seq, gap} record is queued in a FIFO for
// downstream logging.
//
// Parameters
//   POLL_INTERVAL  idle cycles between the end of one poll and the next read
//   DEPTH          event FIFO depth (power of two, >= 2)
//
// Ports
//   clock, reset             clock (rising edge), async active-low reset
//   io_Avalon_address        always 0
//   io_Avalon_read           read strobe, held until waitrequest drops
//   io_Avalon_readdata       slave snapshot
//   io_Avalon_waitrequest    slave stall
//   io_enable                enables polling; an in-flight poll always completes
//   io_evt_valid/ready       event stream handshake (valid = FIFO non-empty)
//   io_evt_code/seq/gap      FIFO head record
//   io_evt_time              read-accept timestamp of the head record
//   io_dropped               saturating count of records lost to a full FIFO
//
// Optional feature macro: DBG_POLL_TIMESTAMP_EN
//   When defined, a 32-bit free-running cycle counter is sampled at each
//   read-accept cycle and stored with the record. When undefined, the counter
//   and the FIFO timestamp field are absent and io_evt_time is tied to 0.
//
// state | meaning
// IDLE  | counting interval cycles while enabled; counter holds when disabled
// READ  | read strobe high, waiting for waitrequest low to capture the snapshot
// EVAL  | compare snapshot seq against last_seq, push or drop the record

module avalon_debug_event_poller #(
  parameter int POLL_INTERVAL = 16,
  parameter int DEPTH         = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_Avalon_address,
  output logic        io_Avalon_read,
  input  logic [63:0] io_Avalon_readdata,
  input  logic        io_Avalon_waitrequest,
  input  logic        io_enable,
  output logic        io_evt_valid,
  input  logic        io_evt_ready,
  output logic [4:0]  io_evt_code,
  output logic [7:0]  io_evt_seq,
  output logic [7:0]  io_evt_gap,
  output logic [31:0] io_evt_time,
  output logic [15:0] io_dropped
);

  localparam int CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_INTERVAL - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EVAL = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  code;
    logic [7:0]  seq;
    logic [7:0]  gap;
`ifdef DBG_POLL_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } rec_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          read_q, read_d;
  logic [7:0]    snap_seq_q, snap_seq_d;
  logic [4:0]    snap_code_q, snap_code_d;
  logic [7:0]    last_seq_q, last_seq_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   dropped_q, dropped_d;
  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];

`ifdef DBG_POLL_TIMESTAMP_EN
  logic [31:0]   ts_q, ts_d;
  logic [31:0]   snap_ts_q, snap_ts_d;
`endif

  logic          evt_new;
  logic          pop;
  logic          push;
  logic          fifo_full;
  rec_t          new_rec;
  rec_t          head;

  // Only the sequence and code fields of the snapshot are meaningful.
  logic [50:0]   unused_readdata;
  assign unused_readdata = io_Avalon_readdata[55:5];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    snap_seq_d  = snap_seq_q;
    snap_code_d = snap_code_q;
    last_seq_d  = last_seq_q;
    evt_new     = 1'b0;
`ifdef DBG_POLL_TIMESTAMP_EN
    ts_d        = ts_q + 32'd1;
    snap_ts_d   = snap_ts_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (io_enable) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_READ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_READ: begin
        if (!io_Avalon_waitrequest) begin
          snap_seq_d  = io_Avalon_readdata[63:56];
          snap_code_d = io_Avalon_readdata[4:0];
`ifdef DBG_POLL_TIMESTAMP_EN
          snap_ts_d   = ts_q;
`endif
          state_d     = ST_EVAL;
        end
      end
      ST_EVAL: begin
        evt_new    = (snap_seq_q != last_seq_q);
        last_seq_d = snap_seq_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered strobe: rises on entry to READ, falls the cycle after accept.
    read_d = (state_d == ST_READ);
  end

  always_comb begin
    new_rec      = '0;
    new_rec.code = snap_code_q;
    new_rec.seq  = snap_seq_q;
    // 8-bit wrap gives the missed-event count across sequence roll-over.
    new_rec.gap  = snap_seq_q - last_seq_q - 8'd1;
`ifdef DBG_POLL_TIMESTAMP_EN
    new_rec.ts   = snap_ts_q;
`endif
  end

  assign fifo_full = (count_q == FULL_CNT);
  assign pop       = (count_q != '0) && io_evt_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push      = evt_new && (!fifo_full || pop);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_rec;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (evt_new && !push && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      read_q      <= 1'b0;
      snap_seq_q  <= '0;
      snap_code_q <= '0;
      last_seq_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dropped_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef DBG_POLL_TIMESTAMP_EN
      ts_q        <= '0;
      snap_ts_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_q      <= read_d;
      snap_seq_q  <= snap_seq_d;
      snap_code_q <= snap_code_d;
      last_seq_q  <= last_seq_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dropped_q   <= dropped_d;
      mem_q       <= mem_d;
`ifdef DBG_POLL_TIMESTAMP_EN
      ts_q        <= ts_d;
      snap_ts_q   <= snap_ts_d;
`endif
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign io_Avalon_address = 1'b0;
  assign io_Avalon_read    = read_q;
  assign io_evt_valid      = (count_q != '0);
  assign io_evt_code       = head.code;
  assign io_evt_seq        = head.seq;
  assign io_evt_gap        = head.gap;
  assign io_dropped        = dropped_q;
`ifdef DBG_POLL_TIMESTAMP_EN
  assign io_evt_time       = head.ts;
`else
  assign io_evt_time       = 32'd0;
`endif

endmodule

// File: tb/tb_avalon_debug_event_poller.sv
`timescale 1ns/1ps
module tb_avalon_debug_event_poller;

  localparam int PI    = 4;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        addr;
  logic        rd;
  logic [63:0] rdata = '0;
  logic        wreq  = 1'b0;
  logic        en    = 1'b0;
  logic        valid;
  logic        ready = 1'b0;
  logic [4:0]  code;
  logic [7:0]  seq;
  logic [7:0]  gap;
  logic [31:0] etime;
  logic [15:0] dropped;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  avalon_debug_event_poller #(.POLL_INTERVAL(PI), .DEPTH(DEPTH)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_Avalon_address     (addr),
    .io_Avalon_read        (rd),
    .io_Avalon_readdata    (rdata),
    .io_Avalon_waitrequest (wreq),
    .io_enable             (en),
    .io_evt_valid          (valid),
    .io_evt_ready          (ready),
    .io_evt_code           (code),
    .io_evt_seq            (seq),
    .io_evt_gap            (gap),
    .io_evt_time           (etime),
    .io_dropped            (dropped)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    while (!(rd && !wreq) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s timeout waiting for read accept", name);
    end
  endtask

  task automatic wait_read(input string name);
    int n = 0;
    while (!rd && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s timeout waiting for read strobe", name);
    end
  endtask

  // Cycle counter mirroring the timestamp semantics (0 in the first cycle after reset).
  int unsigned cyc;
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model: event queue driven by observed read accepts.
  typedef struct {
    logic [4:0]  code;
    logic [7:0]  seq;
    logic [7:0]  gap;
    logic [31:0] t;
  } rec_t;

  rec_t        mq[$];
  logic [7:0]  m_last = '0;
  int          m_dropped = 0;
  bit          m_eval = 0;
  logic [7:0]  p_seq = '0;
  logic [4:0]  p_code = '0;
  logic [31:0] p_time = '0;

  always @(negedge clock) begin
    if (!reset) begin
      mq.delete();
      m_last    = '0;
      m_dropped = 0;
      m_eval    = 0;
    end else begin : mon
      bit   do_pop;
      bit   do_push;
      bit   acc;
      rec_t r;
      do_push = 0;
      chk("mon_valid", valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("mon_code", code, mq[0].code);
        chk("mon_seq", seq, mq[0].seq);
        chk("mon_gap", gap, mq[0].gap);
`ifdef DBG_POLL_TIMESTAMP_EN
        chk("mon_time", etime, mq[0].t);
`endif
      end
`ifndef DBG_POLL_TIMESTAMP_EN
      chk("mon_time_zero", etime, 0);
`endif
      chk("mon_dropped", dropped, m_dropped);
      chk("mon_addr", addr, 0);
      do_pop = (mq.size() != 0) && ready;
      acc    = rd && !wreq;
      if (m_eval && (p_seq != m_last)) begin
        r.code = p_code;
        r.seq  = p_seq;
        r.gap  = p_seq - m_last - 8'd1;
        r.t    = p_time;
        if (mq.size() < DEPTH || do_pop) do_push = 1;
        else if (m_dropped < 65535) m_dropped++;
      end
      if (m_eval) m_last = p_seq;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(r);
      m_eval = acc;
      if (acc) begin
        p_seq  = rdata[63:56];
        p_code = rdata[4:0];
        p_time = cyc;
      end
    end
  end

  typedef struct {
    logic [7:0] seq;
    logic [4:0] code;
    bit         is_evt;
    logic [7:0] gap;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    logic [7:0]  rseq;
    logic [31:0] t_acc;

    vecs[0] = '{8'h01, 5'h13, 1, 8'h00};
    vecs[1] = '{8'h01, 5'h07, 0, 8'h00};
    vecs[2] = '{8'h05, 5'h0A, 1, 8'h03};
    vecs[3] = '{8'hFE, 5'h1F, 1, 8'hF8};
    vecs[4] = '{8'h02, 5'h11, 1, 8'h03};
    vecs[5] = '{8'h02, 5'h04, 0, 8'h00};
    vecs[6] = '{8'h03, 5'h00, 1, 8'h00};
    vecs[7] = '{8'h00, 5'h05, 1, 8'hFC};

    // Reset state
    repeat (3) step();
    chk("rst_read", rd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_code", code, 0);
    chk("rst_seq", seq, 0);
    chk("rst_gap", gap, 0);
    chk("rst_time", etime, 0);
    chk("rst_dropped", dropped, 0);
    reset = 1'b1;
    en    = 1'b1;

    // Table-driven single polls: record contents and poll period
    for (int i = 0; i < 8; i++) begin
      rdata = {vecs[i].seq, 51'h0, vecs[i].code};
      wait_accept("vec_accept");
      step();
      step();
      chk("vec_valid", valid, vecs[i].is_evt);
      if (vecs[i].is_evt) begin
        chk("vec_code", code, vecs[i].code);
        chk("vec_seq", seq, vecs[i].seq);
        chk("vec_gap", gap, vecs[i].gap);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      k = 3;
      while (!rd && k < 60) begin
        step();
        k++;
      end
      chk("vec_period", k, 2 + PI);
    end

    // Waitrequest held high for 10 read cycles
    wreq  = 1'b1;
    rdata = {8'h40, 51'h0, 5'h09};
    wait_read("wait_read");
    for (int c = 0; c < 10; c++) begin
      chk("wait_read_hi", rd, 1);
      rdata = {8'(8'h41 + c), 51'h0, 5'h1E};
      step();
    end
    wreq  = 1'b0;
    rdata = {8'h50, 51'h0, 5'h0C};
    wait_accept("wait_accept");
    step();
    chk("wait_read_drop", rd, 0);
    step();
    chk("wait_valid", valid, 1);
    chk("wait_seq", seq, 8'h50);
    chk("wait_code", code, 5'h0C);
    chk("wait_gap", gap, 8'h4F);
    ready = 1'b1;
    step();
    ready = 1'b0;

    // FIFO overflow: 10 events, no consumer
    for (int i = 0; i < 10; i++) begin
      rdata = {8'(8'h60 + i), 51'h0, 5'(i)};
      wait_accept("full_accept");
      step();
    end
    step();
    chk("full_valid", valid, 1);
    chk("full_dropped", dropped, 2);
    chk("full_head_gap", gap, 8'h0F);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", valid, 1);
      chk("drain_seq", seq, 8'(8'h60 + i));
      step();
    end
    chk("drain_empty", valid, 0);
    ready = 1'b0;

    // Disable during READ: poll completes, then block parks
    wreq  = 1'b1;
    rdata = {8'h70, 51'h0, 5'h15};
    wait_read("en_read");
    en = 1'b0;
    step();
    step();
    wreq = 1'b0;
    wait_accept("en_accept");
    step();
    step();
    chk("en_valid", valid, 1);
    chk("en_seq", seq, 8'h70);
    chk("en_gap", gap, 8'h06);
    ready = 1'b1;
    step();
    ready = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (rd) n++;
      step();
    end
    chk("en_hold", n, 0);
    en = 1'b1;
    k = 0;
    while (!rd && k < 60) begin
      step();
      k++;
    end
    chk("en_resume", k, PI);

    // Randomized phase, checked by the reference model
    rseq = 8'h70;
    for (int c = 0; c < 3000; c++) begin
      en   = ($urandom_range(0, 9) != 0);
      wreq = ($urandom_range(0, 3) == 0);
      if (((c / 200) % 2) == 0) ready = 1'b0;
      else ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) rseq = rseq + 8'($urandom_range(0, 3));
      rdata = {rseq, 51'($urandom), 5'($urandom)};
      step();
    end

    // Reset in the middle of a stalled read
    en    = 1'b1;
    ready = 1'b0;
    wreq  = 1'b0;
    rdata = {rseq + 8'd1, 51'h0, 5'h02};
    wait_accept("pre_rst_accept");
    step();
    step();
    wreq = 1'b1;
    wait_read("rst_mid_read");
    reset = 1'b0;
    #1;
    chk("mid_rst_read", rd, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_dropped", dropped, 0);
    chk("mid_rst_code", code, 0);
    chk("mid_rst_seq", seq, 0);
    chk("mid_rst_gap", gap, 0);
    chk("mid_rst_time", etime, 0);
    step();
    reset = 1'b1;
    wreq  = 1'b0;
    rdata = {8'h07, 51'h0, 5'h03};
    wait_accept("post_rst_accept");
    t_acc = cyc;
    step();
    step();
    chk("post_rst_valid", valid, 1);
    chk("post_rst_seq", seq, 8'h07);
    chk("post_rst_code", code, 5'h03);
    chk("post_rst_gap", gap, 8'h06);
`ifdef DBG_POLL_TIMESTAMP_EN
    chk("post_rst_time", etime, t_acc);
`else
    chk("post_rst_time", etime, 0);
`endif
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_debug_event_poller.md
# avalon_debug_event_poller

Avalon-MM read master that polls a single-register debug-event capture slave and turns its snapshots into a buffered event stream. Each 64-bit snapshot carries an 8-bit sequence counter in bits [63:56] and the latest 5-bit debug code in bits [4:0]. The block detects new events by sequence change and computes how many events were overwritten between polls. It queues `{code, seq, gap}` records in a FIFO for downstream logging logic. It sits on the host/debug side of the fabric, opposite the capture slave.

## Interface
- `POLL_INTERVAL`, 16: idle cycles between the end of one poll and the next read.
- `DEPTH`, 8: event FIFO depth in entries; power of two, at least 2.
- `clock`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_Avalon_address`  out  1  always 0.
- `io_Avalon_read`  out  1  read strobe.
- `io_Avalon_readdata`  in  64  slave snapshot; valid in the cycle where `read`=1 and `waitrequest`=0.
- `io_Avalon_waitrequest`  in  1  slave stall.
- `io_enable`  in  1  enables polling.
- `io_evt_valid`  out  1  FIFO non-empty.
- `io_evt_ready`  in  1  consumer accept.
- `io_evt_code`  out  5  event code at the FIFO head.
- `io_evt_seq`  out  8  sequence number at the FIFO head.
- `io_evt_gap`  out  8  number of events missed before this one.
- `io_evt_time`  out  32  capture timestamp; see Configuration.
- `io_dropped`  out  16  saturating count of events lost to a full FIFO.

## Operation
- FSM states are IDLE, READ and EVAL. Reset state is IDLE with the interval counter at 0.
- IDLE transitions:
  - If `io_enable`=1, increment the interval counter.
  - When the counter reaches `POLL_INTERVAL`-1, clear it and go to READ.
  - If `io_enable`=0, hold the counter.
- READ:
  - Hold `read`=1.
  - In the first cycle with `waitrequest`=0, capture `readdata[63:56]` into `snap_seq` and `readdata[4:0]` into `snap_code`, then go to EVAL.
  - `read` drops in the cycle after acceptance.
- EVAL takes one cycle, then returns to IDLE:
  - If `snap_seq` == `last_seq`, there is no event.
  - Otherwise form the record `{snap_code, snap_seq, gap}`, where `gap = (snap_seq - last_seq - 1) mod 256` in 8-bit arithmetic.
  - Update `last_seq` to `snap_seq` whether or not the record is stored.
- `last_seq` resets to 0, so the first nonzero sequence after reset counts as an event.
- Push and drop rules:
  - A record is pushed only if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the record is discarded and `io_dropped` increments, saturating at 0xFFFF.
- A pop happens when `io_evt_valid` and `io_evt_ready` are both 1.
- Deasserting `io_enable` during READ does not abort the transaction. The block finishes READ and EVAL, then parks in IDLE.

## Timing
- All outputs reset to 0: `read`, `address`, `evt_valid`, `evt_code`, `evt_seq`, `evt_gap`, `evt_time`, `io_dropped`. FIFO pointers also reset to 0.
- Polls are periodic. The read is accepted at cycle T. EVAL runs at T+1. The next `read` asserts at T+2+`POLL_INTERVAL`, provided `waitrequest` stays low throughout.
- Push latency: a record formed in EVAL at cycle E appears at the FIFO head, with `evt_valid`=1, at E+1 when the FIFO was empty.
- The head fields are registered FIFO outputs and are stable while `evt_valid`=1 and `evt_ready`=0.
- When the FIFO is full, a push and a pop in the same cycle are both honoured. Occupancy stays at `DEPTH`, and the count does not drop.
- Reset asserted mid-READ:
  - `read` falls immediately.
  - The FIFO and `io_dropped` clear.
  - `last_seq` returns to 0.

## Configuration
- `DBG_POLL_TIMESTAMP_EN` defined:
  - A 32-bit free-running cycle counter is compiled in. It resets to 0 and wraps.
  - Its value at the read-accept cycle is stored with each record and presented on `io_evt_time`.
- `DBG_POLL_TIMESTAMP_EN` not defined:
  - The counter and the FIFO timestamp field are absent.
  - `io_evt_time` is tied to 0.

## Test plan
- Single event, `POLL_INTERVAL`=4, slave returns 0x0100_0000_0000_0013 with `waitrequest`=0 → one record: code=0x13, seq=1, gap=0. Next `read` asserts 6 cycles after acceptance.
- Unchanged snapshot on consecutive polls → no push and `evt_valid` stays 0. Then seq jumps from 1 to 5 → record with seq=5, gap=3.
- Wrap-around, `last_seq`=0xFE and the next snapshot seq=0x02 → gap=3.
- `waitrequest` held high for 10 cycles → `read` stays high and stable for those cycles, and the data is captured only in the first low cycle.
- `DEPTH`=8 with `evt_ready`=0 and 10 distinct events → 8 entries queued and `io_dropped`=2. Then with `evt_ready`=1 → events drain in order with seq values intact.
- With the macro defined, `reset` low mid-READ then released → all outputs 0 and `io_evt_time` restarts from 0. The first post-reset event reports a gap relative to `last_seq`=0.
